// File: rtl/count_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : count_uart_tx
//  Description : Watches a 4-bit counter and queues every change in a small
//                FIFO. Each queued value is sent as one ASCII hex character
//                ('0'..'9', 'A'..'F') in a UART 8N1 frame, LSB first, idle high.
//  Ports       : clk        - single rising-edge clock
//                reset      - synchronous active-high reset
//                count      - upstream counter value (synchronous to clk)
//                tx         - registered UART serial output
//                busy       - high while a frame is on tx
//                overflow   - sticky flag: a change was dropped on a full FIFO
//                fifo_level - number of queued entries
//  Revision    : 1.0 - initial release
// ============================================================================
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               count,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_AW:0]   c_FULL      = (c_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_DATA  = 2'b10,
        S_STOP  = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Change detection
    // ------------------------------------------------------------------
    logic [3:0] r_prev_count;
    logic       r_primed;     // low on the first cycle after reset: baseline only

    always_ff @(posedge clk) begin
        r_prev_count <= count;
        if (reset) r_primed <= 1'b0;
        else       r_primed <= 1'b1;
    end

    logic w_push;
    assign w_push = r_primed && !reset && (count != r_prev_count);

    // ------------------------------------------------------------------
    // FIFO (raw 4-bit values; ASCII encoding happens at the pop)
    // ------------------------------------------------------------------
    logic [3:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_level;
    logic            r_overflow;

    logic w_pop;
    logic w_full;
    logic w_push_ok;

    assign w_full    = (r_level == c_FULL);
    // A pop on the same edge frees a slot, so a push into a full FIFO still fits.
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    logic [3:0] w_head;
    logic [7:0] w_head_ascii;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_ascii = (w_head < 4'd10) ? {4'h3, w_head} : (8'h37 + {4'h0, w_head});

    // ------------------------------------------------------------------
    // Transmitter FSM
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_BW-1:0] r_baud;
    logic [c_BW-1:0] w_baud_nxt;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      r_data;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            w_baud_done;

    assign w_baud_done = (r_baud == c_BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
            if (w_pop) r_data <= w_head_ascii;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_pop       = 1'b0;
        // The baud counter only runs inside a frame and restarts at each bit.
        if (r_state == S_IDLE || w_baud_done) w_baud_nxt = '0;
        else                                  w_baud_nxt = r_baud + 1'b1;

        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    if (r_bit == 3'd7) w_state_nxt = S_STOP;
                    else               w_bit_nxt   = r_bit + 3'd1;
                end
            end
            S_STOP: begin
                if (w_baud_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // tx follows the state being entered so it is registered with it.
        if (w_state_nxt == S_START)     w_tx_nxt = 1'b0;
        else if (w_state_nxt == S_DATA) w_tx_nxt = r_data[w_bit_nxt];
        else                            w_tx_nxt = 1'b1;
    end

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

endmodule
`default_nettype wire
